// File: rtl/comparador_arbitro_if.sv
// ============================================================================
// Module      : comparador_arbitro_if
// Description : Bundle of the two requester channels, the comparator operand
//               and code wires, and the tagged response channel of
//               comparador_arbitro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface comparador_arbitro_if #(
    parameter int WIDTH = 32
);
    // Requester 0: core branch unit
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_funct3;

    // Requester 1: timer/compare peripheral
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_funct3;

    // Shared comparator
    logic [WIDTH-1:0] cmp_rs1;
    logic [WIDTH-1:0] cmp_rs2;
    logic [1:0]       cmp_code;

    // Response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic             rsp_taken;
    logic [1:0]       rsp_code;
    logic             rsp_err;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_funct3,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_funct3,
        output req1_ready,
        output cmp_rs1, cmp_rs2,
        input  cmp_code,
        output rsp_valid, rsp_id, rsp_taken, rsp_code, rsp_err,
        input  rsp_ready
    );

    // Requester / consumer / comparator side
    modport master (
        output req0_valid, req0_a, req0_b, req0_funct3,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_funct3,
        input  req1_ready,
        input  cmp_rs1, cmp_rs2,
        output cmp_code,
        input  rsp_valid, rsp_id, rsp_taken, rsp_code, rsp_err,
        output rsp_ready
    );
endinterface

`default_nettype wire

// File: rtl/comparador_arbitro.sv
// ============================================================================
// Module      : comparador / comparador_arbitro
// Description : comparador is the shared, purely combinational unsigned
//               comparator. comparador_arbitro arbitrates it round-robin
//               between two requesters, registers the operands, samples the
//               comparator code and resolves the RISC-V branch condition.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparador #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] rs1_i,
    input  wire logic [WIDTH-1:0] rs2_i,
    output logic      [1:0]       code_o
);
    // bit0 = equal, bit1 = rs1 > rs2 (unsigned); no state inside
    always_comb begin
        code_o    = 2'b00;
        code_o[0] = (rs1_i == rs2_i);
        code_o[1] = (rs1_i >  rs2_i);
    end
endmodule

module comparador_arbitro #(
    parameter int WIDTH = 32
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    comparador_arbitro_if.slave bus
);
    // RISC-V branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic [WIDTH-1:0] cmp_rs1_q;
    logic [WIDTH-1:0] cmp_rs2_q;
    logic [2:0]       funct3_q;
    logic             id_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic             rsp_taken_q;
    logic [1:0]       rsp_code_q;
    logic             rsp_err_q;

    logic             grant_vld;
    logic             grant_id;
    logic [WIDTH-1:0] rs1_d;
    logic [WIDTH-1:0] rs2_d;
    logic [2:0]       funct3_d;

    // Branch resolution from the sampled code; returns {err, taken}.
    // lt is derived as "neither equal nor greater".
    function automatic logic [1:0] resolve(input logic [2:0] f3,
                                           input logic [1:0] code);
        logic       eq;
        logic       lt;
        logic [1:0] r;
        eq = code[0];
        lt = ~code[0] & ~code[1];
        case (f3)
            F3_BEQ:           r = {1'b0, eq};
            F3_BNE:           r = {1'b0, ~eq};
            F3_BLT, F3_BLTU:  r = {1'b0, lt};
            F3_BGE, F3_BGEU:  r = {1'b0, ~lt};
            default:          r = 2'b10;
        endcase
        return r;
    endfunction

    // Round-robin grant: a lone requester wins, contention goes to the one
    // that was not served last.
    always_comb begin
        grant_vld = bus.req0_valid | bus.req1_valid;
        grant_id  = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_q;
        end
    end

    assign bus.req0_ready = (state_q == ST_IDLE) && grant_vld && !grant_id;
    assign bus.req1_ready = (state_q == ST_IDLE) && grant_vld &&  grant_id;

    // Operand mux of the granted requester; signed compares flip the MSB so
    // the unsigned comparator orders two's-complement values correctly.
    always_comb begin
        funct3_d = grant_id ? bus.req1_funct3 : bus.req0_funct3;
        rs1_d    = grant_id ? bus.req1_a      : bus.req0_a;
        rs2_d    = grant_id ? bus.req1_b      : bus.req0_b;
        if ((funct3_d == F3_BLT) || (funct3_d == F3_BGE)) begin
            rs1_d[WIDTH-1] = ~rs1_d[WIDTH-1];
            rs2_d[WIDTH-1] = ~rs2_d[WIDTH-1];
        end
    end

    // Sequencer: accept, one compare cycle, hold response until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cmp_rs1_q    <= '0;
            cmp_rs2_q    <= '0;
            funct3_q     <= 3'b000;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_taken_q  <= 1'b0;
            rsp_code_q   <= 2'b00;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld) begin
                        cmp_rs1_q    <= rs1_d;
                        cmp_rs2_q    <= rs2_d;
                        funct3_q     <= funct3_d;
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                        state_q      <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    rsp_code_q               <= bus.cmp_code;
                    {rsp_err_q, rsp_taken_q} <= resolve(funct3_q, bus.cmp_code);
                    rsp_id_q                 <= id_q;
                    rsp_valid_q              <= 1'b1;
                    state_q                  <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmp_rs1   = cmp_rs1_q;
    assign bus.cmp_rs2   = cmp_rs2_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_taken = rsp_taken_q;
    assign bus.rsp_code  = rsp_code_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_comparador_arbitro.sv
// ============================================================================
// Module      : tb_comparador_arbitro
// Description : Self-checking bench for comparador_arbitro with the shared
//               comparador attached; responses are scored against a queue of
//               expectations filled at each accept.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comparador_arbitro;
    localparam int WIDTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    comparador_arbitro_if #(.WIDTH(WIDTH)) bus ();

    comparador_arbitro #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    comparador #(.WIDTH(WIDTH)) u_cmp (
        .rs1_i  (bus.cmp_rs1),
        .rs2_i  (bus.cmp_rs2),
        .code_o (bus.cmp_code)
    );

    typedef struct packed {
        logic       id;
        logic       taken;
        logic [1:0] code;
        logic       err;
    } rsp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_acc_cyc = 0;
    logic prev_rsp_valid = 1'b0;
    rsp_t exp_q[$];
    int   acc_id_q[$];
    int   acc_cyc_q[$];
    rsp_t e;
    rsp_t snap;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference branch semantics computed with native signed/unsigned ops
    function automatic rsp_t model(input logic id, input logic [31:0] a,
                                   input logic [31:0] b, input logic [2:0] f);
        rsp_t r;
        logic sgn, eq, lt, gt;
        sgn = (f == 3'b100) || (f == 3'b101);
        eq  = (a == b);
        lt  = sgn ? ($signed(a) < $signed(b)) : (a < b);
        gt  = !eq && !lt;
        r.id    = id;
        r.code  = {gt, eq};
        r.err   = 1'b0;
        r.taken = 1'b0;
        case (f)
            3'b000:         r.taken = eq;
            3'b001:         r.taken = !eq;
            3'b100, 3'b110: r.taken = lt;
            3'b101, 3'b111: r.taken = !lt;
            default:        r.err   = 1'b1;
        endcase
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: records accepts, scores responses, checks ready exclusivity
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_exclusive", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
            if (bus.req0_valid && bus.req0_ready) begin
                exp_q.push_back(model(1'b0, bus.req0_a, bus.req0_b, bus.req0_funct3));
                acc_id_q.push_back(0);
                acc_cyc_q.push_back(cyc);
                last_acc_cyc = cyc;
            end
            if (bus.req1_valid && bus.req1_ready) begin
                exp_q.push_back(model(1'b1, bus.req1_a, bus.req1_b, bus.req1_funct3));
                acc_id_q.push_back(1);
                acc_cyc_q.push_back(cyc);
                last_acc_cyc = cyc;
            end
            if (bus.rsp_valid && !prev_rsp_valid)
                check("latency", 64'(cyc - last_acc_cyc), 64'd2);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id",    64'(bus.rsp_id),    64'(e.id));
                    check("rsp_code",  64'(bus.rsp_code),  64'(e.code));
                    check("rsp_taken", 64'(bus.rsp_taken), 64'(e.taken));
                    check("rsp_err",   64'(bus.rsp_err),   64'(e.err));
                end
            end
            prev_rsp_valid = bus.rsp_valid;
        end else begin
            prev_rsp_valid = 1'b0;
        end
    end

    task automatic set_req(input logic id, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] f);
        if (id == 1'b0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_funct3 = f;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_funct3 = f;
        end
    endtask

    // Present one request, hold it until accepted, drop it just after the edge
    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f);
        @(posedge clk); #1;
        set_req(id, 1'b1, a, b, f);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((id == 1'b0) ? bus.req0_ready : bus.req1_ready) begin
                @(posedge clk); #1;
                set_req(id, 1'b0, a, b, f);
                return;
            end
        end
        check("issue_timeout", 64'd1, 64'd0);
        set_req(id, 1'b0, a, b, f);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.rsp_valid) return;
        end
        check("drain_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [2:0] f_tbl [6];

    initial begin
        f_tbl[0] = 3'b000; f_tbl[1] = 3'b001; f_tbl[2] = 3'b100;
        f_tbl[3] = 3'b101; f_tbl[4] = 3'b110; f_tbl[5] = 3'b111;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        set_req(1'b1, 1'b0, 32'h0, 32'h0, 3'b000);
        bus.rsp_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmp_rs1",   64'(bus.cmp_rs1),   64'd0);
        check("rst_cmp_rs2",   64'(bus.cmp_rs2),   64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
        check("rst_rsp_taken", 64'(bus.rsp_taken), 64'd0);
        check("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
        check("rst_rsp_code",  64'(bus.rsp_code),  64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // req0 BEQ with equal operands
        set_req(1'b0, 1'b1, 32'h0000_1234, 32'h0000_1234, 3'b000);
        @(negedge clk);
        check("beq_ready_c0", 64'(bus.req0_ready), 64'd1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 32'h0000_1234, 32'h0000_1234, 3'b000);
        @(negedge clk);
        check("beq_rsp_valid_c1", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        check("beq_rsp_valid_c2", 64'(bus.rsp_valid), 64'd1);
        wait_drain();

        // Signed vs unsigned on req1
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100);
        check("blt_cmp_rs1", 64'(bus.cmp_rs1), 64'h7FFF_FFFF);
        check("blt_cmp_rs2", 64'(bus.cmp_rs2), 64'h8000_0001);
        wait_drain();
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110);
        check("bltu_cmp_rs1", 64'(bus.cmp_rs1), 64'hFFFF_FFFF);
        wait_drain();
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b101);
        wait_drain();

        // Contention: both valid continuously for four accepts
        acc_id_q.delete();
        acc_cyc_q.delete();
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 32'h0000_0003, 32'h0000_0007, 3'b100);
        set_req(1'b1, 1'b1, 32'h0000_0009, 32'h0000_0009, 3'b001);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (acc_id_q.size() >= 4) break;
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("cont_accepts", 64'(acc_id_q.size()), 64'd4);
        for (int i = 0; i < acc_id_q.size() && i < 4; i++)
            check("cont_id_seq", 64'(acc_id_q[i]), 64'(i % 2));
        for (int i = 1; i < acc_cyc_q.size() && i < 4; i++)
            check("cont_spacing", 64'(acc_cyc_q[i] - acc_cyc_q[i-1]), 64'd3);
        wait_drain();

        // Backpressure with req1 pending during RESPOND
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        issue(1'b0, 32'h0000_0010, 32'h0000_0020, 3'b110);
        set_req(1'b1, 1'b1, 32'h0000_0001, 32'h0000_0002, 3'b001);
        @(negedge clk);
        @(negedge clk);
        check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        snap = '{id: bus.rsp_id, taken: bus.rsp_taken, code: bus.rsp_code, err: bus.rsp_err};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_hold_rsp", 64'({bus.rsp_id, bus.rsp_taken, bus.rsp_code, bus.rsp_err}),
                  64'(snap));
            check("bp_no_ready", 64'(bus.req0_ready | bus.req1_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_no_ready_hs", 64'(bus.req1_ready), 64'd0);
        @(negedge clk);
        check("bp_next_accept", 64'(bus.req1_ready), 64'd1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        wait_drain();

        // Illegal funct3
        issue(1'b0, 32'd5, 32'd5, 3'b010);
        wait_drain();
        issue(1'b1, 32'd7, 32'd3, 3'b011);
        wait_drain();

        // Randomised mix through the scoreboard
        for (int n = 0; n < 10; n++) begin
            logic [31:0] a, b;
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            issue(1'($urandom_range(0, 1)), a, b, f_tbl[$urandom_range(0, 5)]);
            wait_drain();
        end

        // Reset during COMPARE drops the op
        issue(1'b0, 32'h0000_AAAA, 32'h0000_5555, 3'b000);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_cmp_rs1",   64'(bus.cmp_rs1),   64'd0);
        check("midrst_cmp_rs2",   64'(bus.cmp_rs2),   64'd0);
        check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(1'b1, 1'b1, 32'h0000_0002, 32'h0000_0001, 3'b111);
        @(negedge clk);
        check("postrst_req1_ready", 64'(bus.req1_ready), 64'd1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        wait_drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
